// File: rtl/frame_pkg.sv
// frame_pkg: frame geometry constants and load-state encoding shared by the frame store.
package frame_pkg;
    localparam int IMAGE_WIDTH   = 240;
    localparam int IMAGE_HEIGHT  = 180;
    localparam int BYTES_PER_ROW = IMAGE_WIDTH / 8;
    localparam int FRAME_BYTES   = BYTES_PER_ROW * IMAGE_HEIGHT;
    localparam int FRAME_ADDR_W  = 13;
    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;
endpackage

// File: rtl/frame_bram.sv
// frame_bram: simple dual-port frame RAM, one write port and one synchronous read port.
module frame_bram
    import frame_pkg::*;
#(
    parameter int DEPTH = FRAME_BYTES
) (
    input  logic                    clk,
    input  logic                    writeEnable,
    input  logic [FRAME_ADDR_W-1:0] writeAddress,
    input  logic [7:0]              writeData,
    input  logic                    readEnable,
    input  logic [FRAME_ADDR_W-1:0] readAddress,
    output logic [7:0]              readData
);
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (writeEnable) mem[writeAddress] <= writeData;
        if (readEnable) readData <= mem[readAddress];
    end
endmodule

// File: rtl/binary_frame_store.sv
// binary_frame_store: byte-loaded binary frame answering pixel reads with a fixed 2-cycle latency.
module binary_frame_store
    import frame_pkg::*;
#(
    parameter int IMAGE_WIDTH  = frame_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = frame_pkg::IMAGE_HEIGHT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       loadStart,
    input  logic       loadValid,
    input  logic [7:0] loadByte,
    output logic       loadReady,
    input  logic [7:0] xAddressIn,
    input  logic [7:0] yAddressIn,
    output logic       dataOut,
    output logic       frameLoaded
);
    state_t                  state, nextState;
    logic [FRAME_ADDR_W-1:0] loadCount, yWide, rowBase, readAddress;
    logic                    accept, lastByte, readGate, gateD1;
    logic [2:0]              bitSelD1;
    logic [7:0]              readByte;

    assign accept      = loadValid && state == LOAD;
    assign lastByte    = accept && loadCount == FRAME_ADDR_W'(FRAME_BYTES - 1);
    // y*30 as (y<<5)-(y<<1) keeps the address path multiplier-free
    assign yWide       = FRAME_ADDR_W'(yAddressIn);
    assign rowBase     = (yWide << 5) - (yWide << 1);
    assign readAddress = rowBase + FRAME_ADDR_W'(xAddressIn[7:3]);
    assign readGate    = state == READY && xAddressIn < 8'(IMAGE_WIDTH) && yAddressIn < 8'(IMAGE_HEIGHT);

    frame_bram u_bram (
        .clk          (clk),
        .writeEnable  (accept),
        .writeAddress (loadCount),
        .writeData    (loadByte),
        .readEnable   (readGate),
        .readAddress  (readAddress),
        .readData     (readByte)
    );

    always_comb begin
        nextState   = state;
        if (state != LOAD && loadStart) nextState = LOAD;
        else if (lastByte) nextState = READY;
        loadReady   = state == LOAD;
        frameLoaded = state == READY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            loadCount <= '0;
            gateD1    <= 1'b0;
            bitSelD1  <= 3'd0;
            dataOut   <= 1'b0;
        end else begin
            state     <= nextState;
            loadCount <= state != LOAD ? '0 : accept ? loadCount + 1'b1 : loadCount;
            gateD1    <= readGate;
            bitSelD1  <= xAddressIn[2:0];
            dataOut   <= readByte[bitSelD1] & gateD1;
        end
    end
endmodule

// File: tb/tb_binary_frame_store.sv
// tb_binary_frame_store: directed self-checking bench for binary_frame_store.
module tb_binary_frame_store;
    logic       clk = 1'b0;
    logic       reset, loadStart, loadValid, loadReady, dataOut, frameLoaded;
    logic [7:0] loadByte, xAddressIn, yAddressIn;
    int         compared = 0;
    int         mismatched = 0;

    binary_frame_store dut (
        .clk         (clk),
        .reset       (reset),
        .loadStart   (loadStart),
        .loadValid   (loadValid),
        .loadByte    (loadByte),
        .loadReady   (loadReady),
        .xAddressIn  (xAddressIn),
        .yAddressIn  (yAddressIn),
        .dataOut     (dataOut),
        .frameLoaded (frameLoaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: all 0x01, mode 1: checkerboard, mode 2: (k*7+3) mod 256
    function automatic logic [7:0] frameByte(input int mode, input int k);
        if (mode == 0) return 8'h01;
        if (mode == 1) return ((k / 30) % 2 == 1) ? 8'h55 : 8'hAA;
        return 8'((k * 7 + 3) % 256);
    endfunction

    function automatic logic pixel(input int mode, input int x, input int y);
        logic [7:0] b;
        b = frameByte(mode, y * 30 + x / 8);
        return b[x % 8];
    endfunction

    task automatic loadFrame(input int mode, input bit toggle, input int abortAt);
        int k = 0;
        bit phase = 1'b0;
        loadStart = 1'b1;
        @(negedge clk);
        loadStart = 1'b0;
        check("load_ready_entry", loadReady, 1);
        check("frame_loaded_entry", frameLoaded, 0);
        while (k < 5400 && k != abortAt) begin
            loadValid = !toggle || phase;
            loadByte  = loadValid ? frameByte(mode, k) : ~frameByte(mode, k);
            if (loadValid && k == 5399) begin
                check("frame_loaded_before_last", frameLoaded, 0);
                check("load_ready_before_last", loadReady, 1);
            end
            @(negedge clk);
            if (loadValid) k++;
            phase = !phase;
        end
        loadValid = 1'b0;
        if (abortAt < 0) begin
            check("frame_loaded_after_last", frameLoaded, 1);
            check("load_ready_after_last", loadReady, 0);
        end
    endtask

    task automatic readOne(input string tag, input int x, input int y, input logic exp);
        xAddressIn = 8'(x);
        yAddressIn = 8'(y);
        @(negedge clk);
        xAddressIn = 8'hFF;
        yAddressIn = 8'hFF;
        @(negedge clk);
        check(tag, dataOut, exp);
    endtask

    initial begin
        logic pe1 = 1'b0;
        logic pe2 = 1'b0;
        reset = 1'b1; loadStart = 1'b0; loadValid = 1'b0; loadByte = 8'h00;
        xAddressIn = 8'h00; yAddressIn = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_load_ready", loadReady, 0);
        check("rst_frame_loaded", frameLoaded, 0);
        check("rst_data_out", dataOut, 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_load_ready", loadReady, 0);
        check("idle_frame_loaded", frameLoaded, 0);
        readOne("idle_read_0_0", 0, 0, 0);
        readOne("idle_read_5_5", 5, 5, 0);

        loadFrame(0, 1'b0, -1);
        xAddressIn = 8'd0; yAddressIn = 8'd0;
        @(negedge clk);
        xAddressIn = 8'hFF; yAddressIn = 8'hFF;
        check("latency_not_1", dataOut, 0);
        @(negedge clk);
        check("ones_read_0_0", dataOut, 1);
        readOne("ones_read_1_0", 1, 0, 0);
        readOne("ones_read_8_0", 8, 0, 1);
        readOne("ones_read_232_179", 232, 179, 1);

        loadFrame(1, 1'b1, -1);
        for (int i = 0; i < 43202; i++) begin
            if (i >= 2) check("stream", dataOut, pe2);
            pe2 = pe1;
            if (i < 43200) begin
                xAddressIn = 8'(i % 240);
                yAddressIn = 8'(i / 240);
                pe1 = 1'((i % 240 + i / 240) % 2);
            end else begin
                xAddressIn = 8'hFF;
                yAddressIn = 8'hFF;
                pe1 = 1'b0;
            end
            @(negedge clk);
        end
        readOne("oob_240_0", 240, 0, 0);
        readOne("oob_0_180", 0, 180, 0);
        readOne("oob_255_255", 255, 255, 0);
        readOne("edge_239_0", 239, 0, 1);
        readOne("edge_0_179", 0, 179, 1);
        readOne("edge_239_179", 239, 179, 0);

        loadFrame(2, 1'b1, 3000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_load_ready", loadReady, 0);
        check("abort_frame_loaded", frameLoaded, 0);
        readOne("abort_idle_read", 0, 0, 0);
        loadFrame(2, 1'b0, -1);
        readOne("pat_0_0", 0, 0, 1);
        readOne("pat_9_1", 9, 1, 0);
        readOne("pat_7_179", 7, 179, 1);
        readOne("pat_123_97", 123, 97, pixel(2, 123, 97));
        readOne("pat_200_150", 200, 150, pixel(2, 200, 150));

        xAddressIn = 8'd7; yAddressIn = 8'd179;
        loadStart = 1'b1;
        @(negedge clk);
        loadStart = 1'b0;
        check("reload_frame_loaded", frameLoaded, 0);
        check("reload_load_ready", loadReady, 1);
        @(negedge clk);
        xAddressIn = 8'hFF; yAddressIn = 8'hFF;
        check("reload_old_read", dataOut, 1);
        @(negedge clk);
        check("reload_gated_read", dataOut, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
